// File: rtl/out_bcd_conv.sv
`default_nettype none
// ============================================================================
//  Module   : out_bcd_conv
//  Brief    : Converts each new CPU output word to packed BCD, one bit per cycle.
//  Revision : 1.0
// ============================================================================
module out_bcd_conv #(
    parameter int DATA_WIDTH = 16,
    parameter int DIGITS     = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [DATA_WIDTH-1:0]   in,
    output logic [4*DIGITS-1:0]     bcd,
    output logic                    busy,
    output logic                    valid
);

    localparam int c_CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [DATA_WIDTH-1:0]   r_last_val;
    logic [DATA_WIDTH-1:0]   r_bin_sr;
    logic [4*DIGITS-1:0]     r_bcd_sr;
    logic [4*DIGITS-1:0]     r_bcd;
    logic [c_CNT_W-1:0]      r_cnt;
    logic [4*DIGITS-1:0]     w_adj;
    logic                    w_capture;
    logic                    w_last;

    // Add-3 correction per digit before each shift; 4-bit wrap is never reached.
    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign w_adj[4*gi +: 4] = (r_bcd_sr[4*gi +: 4] >= 4'd5)
                                    ? r_bcd_sr[4*gi +: 4] + 4'd3
                                    : r_bcd_sr[4*gi +: 4];
        end
    endgenerate

    assign w_last = (r_cnt == c_CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_capture = 1'b0;
        case (r_state)
            IDLE: begin
                if (in != r_last_val) begin
                    w_capture = 1'b1;
                    w_next    = SHIFT;
                end
            end
            SHIFT: begin
                if (w_last) begin
                    w_next = DONE;
                end
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_val <= '0;
            r_bin_sr   <= '0;
            r_bcd_sr   <= '0;
            r_cnt      <= '0;
            r_bcd      <= '0;
        end else begin
            if (w_capture) begin
                r_last_val <= in;
                r_bin_sr   <= in;
                r_bcd_sr   <= '0;
                r_cnt      <= '0;
            end else if (r_state == SHIFT) begin
                r_bcd_sr <= {w_adj[4*DIGITS-2:0], r_bin_sr[DATA_WIDTH-1]};
                r_bin_sr <= {r_bin_sr[DATA_WIDTH-2:0], 1'b0};
                r_cnt    <= r_cnt + c_CNT_W'(1);
            end else if (r_state == DONE) begin
                r_bcd <= r_bcd_sr;
            end
        end
    end

    assign bcd   = r_bcd;
    assign busy  = (r_state != IDLE);
    assign valid = (r_state == IDLE);

endmodule
`default_nettype wire

// File: doc/out_bcd_conv.md
Name: out_bcd_conv

Overview:
- Downstream stage of the CPU's `out` port.
- Watches the 16-bit CPU output word and converts every new value from unsigned binary to packed BCD.
- Uses a sequential shift-and-add-3 (double-dabble) engine that shifts one bit per cycle.
- The BCD result feeds the board's seven-segment display driver; `busy`/`valid` tell the display when digits are stable.

Parameters:
- DATA_WIDTH, 16, width of the binary input word (CPU `out`).
- DIGITS, 5, number of BCD digits produced; must satisfy 10^DIGITS > 2^DATA_WIDTH - 1.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous, active-low reset.
- in  input  DATA_WIDTH  binary value, driven directly by CPU `out` (registered, stable between CPU updates).
- bcd  output  4*DIGITS  packed BCD result; digit 0 = [3:0] = ones, digit DIGITS-1 = most significant.
- busy  output  1  high while a conversion is in progress.
- valid  output  1  high when `bcd` equals the BCD of the last captured value.

Behaviour:
- Internal registers:
  - last_val [DATA_WIDTH]: last captured input.
  - bin_sr [DATA_WIDTH]: binary shift register.
  - bcd_sr [4*DIGITS]: BCD scratch.
  - cnt [clog2(DATA_WIDTH)]: shift counter.
  - bcd_reg: output holding register.
  - state.
- Reset (async, immediate):
  - state=IDLE, last_val=0, bin_sr=0, bcd_sr=0, cnt=0, bcd=0.
  - busy=0, valid=1 (0 is already correctly represented).
- busy = (state != IDLE); valid = (state == IDLE). Both decoded combinationally from state, glitch-free.
- State IDLE:
  - If in != last_val at a rising edge: last_val<=in, bin_sr<=in, bcd_sr<=0, cnt<=0, state<=SHIFT.
  - Otherwise hold every register; bcd is unchanged.
- State SHIFT, one step per cycle:
  - For each digit: d' = (d >= 5) ? d+3 : d, a 4-bit add with no carry out.
  - Then {bcd_sr, bin_sr} <= {adjusted bcd_sr, bin_sr} << 1, shifting in 0.
  - cnt<=cnt+1.
  - When cnt == DATA_WIDTH-1 this step is the last one; state<=DONE.
- State DONE: bcd_reg<=bcd_sr, state<=IDLE.
- Latency:
  - Capture edge E0, shift edges E1..E16 (DATA_WIDTH shifts), bcd updated at E17.
  - busy is high after E0 through E17; valid returns high after E17.
  - Total is DATA_WIDTH+1 cycles from capture to result.
- bcd holds the previous result during a conversion and never shows partial values.
- Input change during SHIFT/DONE:
  - Ignored and not captured mid-conversion.
  - On return to IDLE the compare against last_val runs again.
  - A differing value starts a new conversion the cycle after DONE.
  - Intermediate values that revert before IDLE are never shown.
- Input equal to last_val after a change-and-revert: no conversion.
- No overflow is possible given the DIGITS constraint; the top digit may be 0.
- Reset asserted mid-conversion: aborts immediately; outputs return to reset values. After release, a nonzero `in` differs from last_val=0 and triggers a fresh conversion.
- State encoding: 2 bits, IDLE=0, SHIFT=1, DONE=2. Unused encoding 3 goes to IDLE.

Test Plan:
- Reset with in=0, run 50 cycles -> bcd=0x00000, valid=1, busy=0 throughout, no conversion started.
- in=16'd1234 (0x04D2) held -> busy rises after capture edge; after exactly 17 edges bcd=0x01234, valid=1, busy=0.
- in=16'hFFFF -> bcd=0x65535. Then in=16'd9 -> bcd=0x00009, checking that digit add-3 works at both extremes.
- in=100, then in=200 on the 5th cycle of SHIFT -> bcd=0x00100 first; one cycle after IDLE a second conversion begins, ending with bcd=0x00200. bcd never takes any other value.
- in=100, then during SHIFT in=300 and back to 100 before DONE -> single conversion only, bcd=0x00100, busy low after 17 cycles.
- in=4321, assert rst_n low at shift 8, release with in=4321 held -> bcd=0 and valid=1 during reset; new conversion starts on the first edge after release, ending with bcd=0x04321.
